ks_data_path_param: RTL and testbench

- Parametrised successor of the K&S processor data path: instruction register, decoder, program counter, 4-entry register file, ALU, registered flags and memory address mux.
- Controlled cycle-by-cycle by the existing K&S control unit through the same enable/select signals.
- Adds configurable data and address widths, fully defined ALU overflow flags, an illegal-opcode indication and synchronous reset of all state.

---
 rtl/ks_data_path_param_if.sv | 61 ++++++
 rtl/ks_data_path_param.sv | 162 ++++++++++++++++
 tb/tb_ks_data_path_param.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_data_path_param_if.sv
// Shared K&S decode type plus the control/status/data bundle between the
// K&S control unit (master) and the parametrised data path (slave).
//   master: drives branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
//           write_reg_enable, flags_reg_enable, data_in; observes the rest.
//   slave : drives decoded_instruction, illegal_instr, the four flags,
//           ram_addr and data_out.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_BNNEG  = 4'd11,
    I_BNZERO = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

interface ks_data_path_param_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) ();
  logic                                branch;
  logic                                pc_enable;
  logic                                ir_enable;
  logic                                addr_sel;
  logic                                c_sel;
  logic [1:0]                          operation;
  logic                                write_reg_enable;
  logic                                flags_reg_enable;
  k_and_s_pkg::decoded_instruction_type decoded_instruction;
  logic                                illegal_instr;
  logic                                zero_op;
  logic                                neg_op;
  logic                                unsigned_overflow;
  logic                                signed_overflow;
  logic [ADDR_WIDTH-1:0]               ram_addr;
  logic [DATA_WIDTH-1:0]               data_out;
  logic [DATA_WIDTH-1:0]               data_in;

  modport master (
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    input  decoded_instruction, illegal_instr, zero_op, neg_op,
           unsigned_overflow, signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    output decoded_instruction, illegal_instr, zero_op, neg_op,
           unsigned_overflow, signed_overflow, ram_addr, data_out
  );
endinterface

// File: rtl/ks_data_path_param.sv
// K&S processor data path, parametrised in data and address width.
// Holds IR, PC, a 4-entry register file and the flags register; decodes
// ir[15:8], runs the ALU and muxes the memory address. All state is cleared
// by a synchronous active-high reset that overrides every enable.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - slave side of ks_data_path_param_if (controls in, status/data out)
module ks_data_path_param
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  ks_data_path_param_if.slave     bus
);

  localparam int unsigned Msb = DATA_WIDTH - 1;

  logic [15:0]           ir_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] regs_q [4];
  logic                  zero_q, neg_q, uov_q, sov_q;

  decoded_instruction_type dec_op;
  logic                    dec_illegal;
  logic [1:0]              ra, rb, rc;

  logic [DATA_WIDTH-1:0] bus_a, bus_b, alu_res;
  logic [DATA_WIDTH:0]   add_full;
  logic                  alu_uov, alu_sov;
  logic [ADDR_WIDTH-1:0] ir_addr;

  // ir[7] carries no field in any instruction format.
  logic unused_ir;
  assign unused_ir = ir_q[7];

  assign ir_addr = ir_q[ADDR_WIDTH-1:0];

  // Decoder
  always_comb begin
    dec_op      = I_NOP;
    dec_illegal = 1'b0;
    ra          = 2'd0;
    rb          = 2'd0;
    rc          = 2'd0;
    case (ir_q[15:8])
      8'h00: dec_op = I_NOP;
      8'h81: begin
        dec_op = I_LOAD;
        rc     = ir_q[6:5];
      end
      8'h82: begin
        dec_op = I_STORE;
        ra     = ir_q[6:5];
      end
      8'h91: begin
        dec_op = I_MOVE;
        ra     = ir_q[1:0];
        rb     = ir_q[1:0];
        rc     = ir_q[3:2];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        unique case (ir_q[10:8])
          3'd1:    dec_op = I_ADD;
          3'd2:    dec_op = I_SUB;
          3'd3:    dec_op = I_AND;
          default: dec_op = I_OR;
        endcase
        ra = ir_q[1:0];
        rb = ir_q[3:2];
        rc = ir_q[5:4];
      end
      8'h01: dec_op = I_BRANCH;
      8'h02: dec_op = I_BZERO;
      8'h03: dec_op = I_BNEG;
      8'h0A: dec_op = I_BNNEG;
      8'h0B: dec_op = I_BNZERO;
      8'hFF: dec_op = I_HALT;
      default: begin
        dec_op      = I_NOP;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Register file reads are combinational; writes land at the edge, so a
  // same-cycle read always sees the old value.
  assign bus_a = regs_q[ra];
  assign bus_b = regs_q[rb];

  // ALU
  assign add_full = {1'b0, bus_a} + {1'b0, bus_b};

  always_comb begin
    alu_res = '0;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    unique case (bus.operation)
      2'b00: alu_res = bus_a | bus_b;
      2'b01: begin
        alu_res = add_full[DATA_WIDTH-1:0];
        alu_uov = add_full[DATA_WIDTH];
        alu_sov = (bus_a[Msb] == bus_b[Msb]) && (alu_res[Msb] != bus_a[Msb]);
      end
      2'b10: begin
        alu_res = bus_a - bus_b;
        alu_uov = bus_a < bus_b;
        alu_sov = (bus_a[Msb] != bus_b[Msb]) && (alu_res[Msb] != bus_a[Msb]);
      end
      default: alu_res = bus_a & bus_b;
    endcase
  end

  // IR and PC
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= '0;
      pc_q <= '0;
    end else begin
      if (bus.ir_enable) ir_q <= bus.data_in[15:0];
      // Uses the pre-edge IR even when IR is reloaded in the same cycle.
      if (bus.pc_enable) pc_q <= bus.branch ? ir_addr : pc_q + ADDR_WIDTH'(1);
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (bus.write_reg_enable) begin
      regs_q[rc] <= bus.c_sel ? alu_res : bus.data_in;
    end
  end

  // Flags, computed from the operands read before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
    end else if (bus.flags_reg_enable) begin
      zero_q <= (alu_res == '0);
      neg_q  <= alu_res[Msb];
      uov_q  <= alu_uov;
      sov_q  <= alu_sov;
    end
  end

  assign bus.decoded_instruction = dec_op;
  assign bus.illegal_instr       = dec_illegal;
  assign bus.zero_op             = zero_q;
  assign bus.neg_op              = neg_q;
  assign bus.unsigned_overflow   = uov_q;
  assign bus.signed_overflow     = sov_q;
  assign bus.ram_addr            = bus.addr_sel ? pc_q : ir_addr;
  assign bus.data_out            = bus_a;

endmodule

// File: tb/tb_ks_data_path_param.sv
// Self-checking bench for ks_data_path_param: directed steps followed by a
// randomized run, all compared against an instruction-level reference model.
module tb_ks_data_path_param;
  import k_and_s_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst;

  ks_data_path_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ks_data_path_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint unsigned m_reg [4];
  longint unsigned m_ir;
  longint unsigned m_pc;
  bit m_z, m_n, m_u, m_s;

  localparam longint unsigned Mod   = 64'd1 << DW;
  localparam longint unsigned AMod  = 64'd1 << AW;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input longint unsigned ir,
                                     output decoded_instruction_type op,
                                     output int a, output int b, output int c,
                                     output bit ill);
    longint unsigned opc;
    opc = ir / 256;
    op = I_NOP; a = 0; b = 0; c = 0; ill = 0;
    case (opc)
      64'h00: op = I_NOP;
      64'h81: begin op = I_LOAD;  c = int'((ir / 32) % 4); end
      64'h82: begin op = I_STORE; a = int'((ir / 32) % 4); end
      64'h91: begin op = I_MOVE; a = int'(ir % 4); b = a; c = int'((ir / 4) % 4); end
      64'hA1, 64'hA2, 64'hA3, 64'hA4: begin
        op = (opc == 64'hA1) ? I_ADD : (opc == 64'hA2) ? I_SUB :
             (opc == 64'hA3) ? I_AND : I_OR;
        a = int'(ir % 4); b = int'((ir / 4) % 4); c = int'((ir / 16) % 4);
      end
      64'h01: op = I_BRANCH;
      64'h02: op = I_BZERO;
      64'h03: op = I_BNEG;
      64'h0A: op = I_BNNEG;
      64'h0B: op = I_BNZERO;
      64'hFF: op = I_HALT;
      default: ill = 1;
    endcase
  endfunction

  function automatic longint to_signed(input longint unsigned v);
    return (v >= Mod / 2) ? longint'(v) - longint'(Mod) : longint'(v);
  endfunction

  function automatic void ref_alu(input int op, input longint unsigned a, input longint unsigned b,
                                  output longint unsigned r, output bit z, output bit n,
                                  output bit u, output bit s);
    longint sr;
    longint smax, smin;
    smax = longint'(Mod / 2) - 1;
    smin = -longint'(Mod / 2);
    u = 0; s = 0;
    case (op)
      0: r = a | b;
      1: begin
        r  = (a + b) % Mod;
        u  = (a + b) >= Mod;
        sr = to_signed(a) + to_signed(b);
        s  = (sr > smax) || (sr < smin);
      end
      2: begin
        r  = (a + Mod - b) % Mod;
        u  = a < b;
        sr = to_signed(a) - to_signed(b);
        s  = (sr > smax) || (sr < smin);
      end
      default: r = a & b;
    endcase
    z = (r == 0);
    n = (r >= Mod / 2);
  endfunction

  // One clock edge: model next state from pre-edge inputs and state.
  task automatic tick();
    decoded_instruction_type op;
    int a, b, c;
    bit ill, z, n, u, s;
    longint unsigned r, n_ir, n_pc;
    ref_decode(m_ir, op, a, b, c, ill);
    ref_alu(int'(bus.operation), m_reg[a], m_reg[b], r, z, n, u, s);
    n_ir = m_ir;
    n_pc = m_pc;
    if (bus.ir_enable) n_ir = longint'(bus.data_in) % 65536;
    if (bus.pc_enable) n_pc = bus.branch ? (m_ir % AMod) : (m_pc + 1) % AMod;
    @(posedge clk);
    #1;
    if (rst) begin
      m_ir = 0; m_pc = 0;
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
      m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    end else begin
      if (bus.write_reg_enable) m_reg[c] = bus.c_sel ? r : longint'(bus.data_in);
      if (bus.flags_reg_enable) begin
        m_z = z; m_n = n; m_u = u; m_s = s;
      end
      m_ir = n_ir;
      m_pc = n_pc;
    end
  endtask

  task automatic check_all();
    decoded_instruction_type op;
    int a, b, c;
    bit ill;
    #1;
    ref_decode(m_ir, op, a, b, c, ill);
    check("decoded", bus.decoded_instruction, op);
    check("illegal", bus.illegal_instr, ill);
    check("zero", bus.zero_op, m_z);
    check("neg", bus.neg_op, m_n);
    check("uov", bus.unsigned_overflow, m_u);
    check("sov", bus.signed_overflow, m_s);
    check("ram_addr", bus.ram_addr, bus.addr_sel ? m_pc : m_ir % AMod);
    check("data_out", bus.data_out, m_reg[a]);
  endtask

  task automatic idle();
    rst = 0;
    bus.branch = 0; bus.pc_enable = 0; bus.ir_enable = 0; bus.c_sel = 0;
    bus.operation = 2'b00; bus.write_reg_enable = 0; bus.flags_reg_enable = 0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    idle();
    bus.ir_enable = 1;
    bus.data_in = DW'(v);
    tick();
    idle();
  endtask

  task automatic load_reg(input int k, input logic [DW-1:0] v);
    load_ir(16'h8100 | 16'(k << 5));
    bus.write_reg_enable = 1;
    bus.data_in = v;
    tick();
    idle();
  endtask

  task automatic read_reg(input int k, input logic [DW-1:0] v, input string tag);
    load_ir(16'h8200 | 16'(k << 5));
    #1;
    check(tag, bus.data_out, v);
  endtask

  task automatic alu_op(input logic [15:0] instr, input logic [1:0] op);
    load_ir(instr);
    bus.operation = op;
    bus.c_sel = 1;
    bus.write_reg_enable = 1;
    bus.flags_reg_enable = 1;
    tick();
    idle();
  endtask

  logic [7:0] opcodes [14] = '{8'h00, 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                              8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'hFF};

  initial begin
    logic [7:0] lo;
    m_ir = 0; m_pc = 0; m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    idle();
    bus.addr_sel = 1;
    bus.data_in = '0;

    // Reset then fetch
    rst = 1;
    tick();
    idle();
    check_all();
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_decoded", bus.decoded_instruction, I_NOP);
    check("rst_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow}, 0);
    load_ir(16'hA11B);
    check_all();
    check("fetch_add", bus.decoded_instruction, I_ADD);
    bus.pc_enable = 1;
    tick();
    idle();
    check_all();
    check("pc_inc", bus.ram_addr, 1);

    // ADD signed overflow
    load_reg(3, 16'h7FFF);
    load_reg(2, 16'h0001);
    alu_op(16'hA11B, 2'b01);
    check_all();
    check("add_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow},
          4'b0101);
    read_reg(1, 16'h8000, "add_r1");

    // SUB zero then borrow
    load_reg(0, 16'd5);
    load_reg(1, 16'd5);
    alu_op(16'hA224, 2'b10);
    check_all();
    check("sub_zero", {bus.zero_op, bus.unsigned_overflow}, 2'b10);
    load_reg(0, 16'd3);
    alu_op(16'hA224, 2'b10);
    check_all();
    check("sub_borrow", {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow},
          4'b0110);
    read_reg(2, 16'hFFFE, "sub_r2");

    // Branch and wrap
    load_ir(16'h011F);
    bus.pc_enable = 1; bus.branch = 1;
    tick();
    idle();
    bus.pc_enable = 1;
    tick();
    idle();
    check_all();
    check("pc_wrap", bus.ram_addr, 0);
    load_ir(16'h0112);
    bus.pc_enable = 1; bus.branch = 1;
    tick();
    idle();
    check_all();
    check("pc_branch", bus.ram_addr, 5'h12);
    bus.addr_sel = 0;
    check_all();
    check("ir_addr", bus.ram_addr, 5'h12);
    // IR reload and branch on the same edge: PC takes the old IR field.
    load_ir(16'h0107);
    bus.ir_enable = 1; bus.pc_enable = 1; bus.branch = 1; bus.data_in = DW'(16'h0115);
    tick();
    idle();
    bus.addr_sel = 1;
    check_all();
    check("simul_pc", bus.ram_addr, 7);
    bus.addr_sel = 0;
    check_all();
    check("simul_ir", bus.ram_addr, 5'h15);

    // LOAD / STORE
    load_ir(16'h8145);
    bus.data_in = DW'(16'hBEEF);
    bus.write_reg_enable = 1;
    tick();
    idle();
    load_ir(16'h8245);
    check_all();
    check("store_data", bus.data_out, 16'hBEEF);
    check("store_addr", bus.ram_addr, 5);

    // Illegal opcode and reset priority
    load_ir(16'h5500);
    check_all();
    check("illegal", {bus.decoded_instruction, bus.illegal_instr}, {I_NOP, 1'b1});
    rst = 1;
    bus.pc_enable = 1; bus.ir_enable = 1; bus.write_reg_enable = 1; bus.flags_reg_enable = 1;
    bus.data_in = DW'(16'h8245);
    bus.addr_sel = 1;
    tick();
    idle();
    check_all();
    check("rst_pc", bus.ram_addr, 0);
    bus.addr_sel = 0;
    check_all();
    check("rst_ir", {bus.ram_addr, bus.decoded_instruction, bus.illegal_instr}, 0);
    read_reg(2, 16'h0000, "rst_r2");

    // Randomized run
    for (int it = 0; it < 400; it++) begin
      rst                  = ($urandom_range(0, 29) == 0);
      bus.branch           = 1'($urandom);
      bus.pc_enable        = 1'($urandom);
      bus.ir_enable        = ($urandom_range(0, 2) == 0);
      bus.addr_sel         = 1'($urandom);
      bus.c_sel            = 1'($urandom);
      bus.operation        = 2'($urandom);
      bus.write_reg_enable = 1'($urandom);
      bus.flags_reg_enable = 1'($urandom);
      lo = 8'($urandom);
      if ($urandom_range(0, 1) == 0) bus.data_in = DW'({opcodes[$urandom_range(0, 13)], lo});
      else bus.data_in = DW'($urandom);
      tick();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
